// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers for the async FIFO write-side front end.
package fifo_pkg;
    localparam int ADDRSIZE = 4;
    localparam int PTR_W = ADDRSIZE + 1;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

    // Works for any pointer width up to 32 when the Gray code is zero-extended.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) b = b ^ (g >> i);
        return b;
    endfunction
endpackage

// File: rtl/wr_skid_buf.sv
// wr_skid_buf: 2-entry skid buffer with push/pop/flush; head is always presented.
module wr_skid_buf
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [DSIZE-1:0] din_i,
    output skid_state_t      count_o,
    output logic [DSIZE-1:0] head_o
);
    skid_state_t      state_q, state_d;
    logic [DSIZE-1:0] head_q, head_d, tail_q, tail_d;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) state_d = EMPTY;
        else case (state_q)
            EMPTY: if (push_i) begin
                state_d = ONE;
                head_d  = din_i;
            end
            ONE: if (push_i && pop_i) head_d = din_i;
                else if (push_i) begin
                    state_d = TWO;
                    tail_d  = din_i;
                end
                else if (pop_i) state_d = EMPTY;
            TWO: if (pop_i) begin
                state_d = ONE;
                head_d  = tail_q;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign count_o = state_q;
    assign head_o  = head_q;
endmodule

// File: rtl/fifo_wr_frontend.sv
// fifo_wr_frontend: write-domain front end; skid buffer, winc gating and registered fill level.
module fifo_wr_frontend #(
    parameter int DSIZE     = 8,
    parameter int ADDRSIZE  = 4,
    parameter int AF_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                s_valid,
    input  logic [DSIZE-1:0]    s_data,
    output logic                s_ready,
    input  logic                wflush,
    input  logic                wfull,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic                winc,
    output logic [DSIZE-1:0]    wdata,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full
);
    import fifo_pkg::*;

    localparam logic [ADDRSIZE:0] AF = (ADDRSIZE+1)'(AF_THRESH);

    skid_state_t       count;
    logic              accept;
    logic [ADDRSIZE:0] wb, rb, wlevel_d, wlevel_q;
    logic              waf_d, waf_q;

    wr_skid_buf #(.DSIZE(DSIZE)) u_skid (
        .clk_i   (wclk),
        .rst_n_i (wrst_n),
        .push_i  (accept),
        .pop_i   (winc),
        .flush_i (wflush),
        .din_i   (s_data),
        .count_o (count),
        .head_o  (wdata)
    );

    assign s_ready = wrst_n && (count != TWO) && !wflush;
    assign accept  = s_valid && s_ready;
    assign winc    = (count != EMPTY) && !wfull && !wflush;

    // Modular subtract absorbs pointer wrap; the lagging read pointer only overstates.
    always_comb begin
        wb       = (ADDRSIZE+1)'(gray2bin(32'(wptr)));
        rb       = (ADDRSIZE+1)'(gray2bin(32'(wq2_rptr)));
        wlevel_d = wb - rb;
        waf_d    = wlevel_d >= AF;
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wlevel_q <= '0;
            waf_q    <= 1'b0;
        end else begin
            wlevel_q <= wlevel_d;
            waf_q    <= waf_d;
        end
    end

    assign wlevel       = wlevel_q;
    assign walmost_full = waf_q;
endmodule

// File: tb/tb_fifo_wr_frontend.sv
// tb_fifo_wr_frontend: directed vector table plus a queue-model run for ordering under backpressure.
module tb_fifo_wr_frontend;
    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0, s_valid = 1'b1, wflush = 1'b0, wfull = 1'b0;
    logic [7:0] s_data = 8'h55;
    logic [4:0] wptr = '0, wq2_rptr = '0;
    logic       s_ready, winc, walmost_full;
    logic [7:0] wdata;
    logic [4:0] wlevel;

    int checks = 0;
    int errors = 0;
    int dut_pops = 0;
    logic [7:0] q[$];
    logic [7:0] nxt = 8'h01;

    fifo_wr_frontend #(.DSIZE(8), .ADDRSIZE(4), .AF_THRESH(12)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .wflush       (wflush),
        .wfull        (wfull),
        .wptr         (wptr),
        .wq2_rptr     (wq2_rptr),
        .winc         (winc),
        .wdata        (wdata),
        .wlevel       (wlevel),
        .walmost_full (walmost_full)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic       rst_n, valid;
        logic [7:0] data;
        logic       flush, full;
        logic [4:0] wp, rp;
        logic       ready, winc;
        logic [7:0] wdata;
        logic [4:0] level;
        logic       af;
    } vec_t;

    vec_t v[30];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle against a queue model of the skid buffer: ready while <2 held, pop while non-empty and not full.
    task automatic step(input logic val, input logic [7:0] d, input logic full);
        logic m_ready, m_winc;
        @(negedge wclk);
        s_valid = val;
        s_data  = d;
        wfull   = full;
        #1;
        m_ready = q.size() < 2;
        m_winc  = q.size() > 0 && !full;
        chk("model s_ready", 32'(s_ready), 32'(m_ready));
        chk("model winc", 32'(winc), 32'(m_winc));
        if (winc) dut_pops++;
        if (m_winc) begin
            chk("model wdata", 32'(wdata), 32'(q[0]));
            void'(q.pop_front());
        end
        if (val && m_ready) begin
            q.push_back(d);
            nxt++;
        end
    endtask

    initial begin
        //         rst  val  data   fl   full wp     rp      rdy  winc wdata  level   af
        v[0]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 8'h00, 5'd0,  1'b0};
        v[1]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 8'h00, 5'd0,  1'b0};
        v[2]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 8'h00, 5'd0,  1'b0};
        v[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 8'h00, 5'd0,  1'b0};
        v[4]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 8'h00, 5'd0,  1'b0};
        v[5]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 8'h11, 5'd0,  1'b0};
        v[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 8'h22, 5'd0,  1'b0};
        v[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 8'h22, 5'd0,  1'b0};
        v[8]  = '{1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 8'h22, 5'd0,  1'b0};
        v[9]  = '{1'b1, 1'b1, 8'hA2, 1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 8'hA1, 5'd0,  1'b0};
        v[10] = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 8'hA1, 5'd0,  1'b0};
        v[11] = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 8'hA1, 5'd0,  1'b0};
        v[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 8'hA2, 5'd0,  1'b0};
        v[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 8'hA2, 5'd0,  1'b0};
        v[14] = '{1'b1, 1'b1, 8'hB1, 1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 8'hA2, 5'd0,  1'b0};
        v[15] = '{1'b1, 1'b1, 8'hB2, 1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 8'hB1, 5'd0,  1'b0};
        v[16] = '{1'b1, 1'b1, 8'hB3, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 8'hB1, 5'd0,  1'b0};
        v[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 8'hB1, 5'd0,  1'b0};
        v[18] = '{1'b1, 1'b1, 8'hC1, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 8'hB1, 5'd0,  1'b0};
        v[19] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 8'hB1, 5'd0,  1'b0};
        v[20] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd2,  5'd22, 1'b1, 1'b0, 8'hB1, 5'd0,  1'b0};
        v[21] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd4,  5'd22, 1'b1, 1'b0, 8'hB1, 5'd8,  1'b0};
        v[22] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd24, 5'd0,  1'b1, 1'b0, 8'hB1, 5'd12, 1'b1};
        v[23] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd14, 5'd0,  1'b1, 1'b0, 8'hB1, 5'd16, 1'b1};
        v[24] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 8'hB1, 5'd11, 1'b0};
        v[25] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 8'hB1, 5'd0,  1'b0};
        v[26] = '{1'b1, 1'b1, 8'hD1, 1'b0, 1'b0, 5'd24, 5'd0,  1'b1, 1'b0, 8'hB1, 5'd0,  1'b0};
        v[27] = '{1'b0, 1'b1, 8'hD2, 1'b0, 1'b1, 5'd24, 5'd0,  1'b0, 1'b0, 8'hD1, 5'd16, 1'b1};
        v[28] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 8'h00, 5'd0,  1'b0};
        v[29] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 8'h00, 5'd0,  1'b0};

        @(posedge wclk);
        for (int i = 0; i < 30; i++) begin
            @(negedge wclk);
            wrst_n   = v[i].rst_n;
            s_valid  = v[i].valid;
            s_data   = v[i].data;
            wflush   = v[i].flush;
            wfull    = v[i].full;
            wptr     = v[i].wp;
            wq2_rptr = v[i].rp;
            #1;
            chk($sformatf("v%0d s_ready", i), 32'(s_ready), 32'(v[i].ready));
            chk($sformatf("v%0d winc", i), 32'(winc), 32'(v[i].winc));
            chk($sformatf("v%0d wdata", i), 32'(wdata), 32'(v[i].wdata));
            chk($sformatf("v%0d wlevel", i), 32'(wlevel), 32'(v[i].level));
            chk($sformatf("v%0d walmost_full", i), 32'(walmost_full), 32'(v[i].af));
        end

        for (int i = 0; i < 16; i++) step(1'b1, 8'(i + 1), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("stream pops", 32'(dut_pops), 32'd16);

        for (int i = 0; i < 300; i++) step(1'($urandom_range(1)), nxt, $urandom_range(3) == 0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
        @(negedge wclk);
        #1;
        chk("drained winc", 32'(winc), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_frontend.md
Name: fifo_wr_frontend

Overview:
Write-domain front end for the async FIFO. It sits between an upstream valid/ready producer and the write-pointer/full stage.
- Buffers up to 2 words in a skid buffer.
- Drives winc/wdata into the pointer stage and memory, honouring wfull.
- Derives a registered write-side fill level and an almost-full flag from the Gray write pointer and the synchronized Gray read pointer.

Parameters:
DSIZE, 8, data word width
ADDRSIZE, 4, FIFO address width; pointers are ADDRSIZE+1 bits
AF_THRESH, 12, fill level at which walmost_full asserts; legal range 1..2**ADDRSIZE

Ports:
wclk  input  1  write-domain clock
wrst_n  input  1  synchronous active-low reset
s_valid  input  1  upstream word valid
s_data  input  DSIZE  upstream word
s_ready  output  1  front end can accept a word this cycle
wflush  input  1  synchronous discard of buffered words
wfull  input  1  registered full flag from the pointer stage
wptr  input  ADDRSIZE+1  Gray write pointer from the pointer stage
wq2_rptr  input  ADDRSIZE+1  Gray read pointer, 2-flop synchronized into wclk
winc  output  1  write strobe to the pointer stage and memory
wdata  output  DSIZE  write data to memory
wlevel  output  ADDRSIZE+1  registered FIFO occupancy as seen by the write side
walmost_full  output  1  registered, wlevel >= AF_THRESH

Behaviour:
- Reset and clocking: one clock, wclk. wrst_n is synchronous and active-low. All state is sampled at posedge wclk when wrst_n==0.
- Reset values: count=0, s_ready=0 during reset and 1 from the first cycle after release, winc=0, wdata=0, wlevel=0, walmost_full=0.
- Skid buffer states (count): EMPTY(0), ONE(1), TWO(2). Entries are head/tail; wdata always shows head.
- s_ready = (count != TWO) && !wflush. It decodes registered state only; there is no combinational path from wfull or s_valid.
- Push (accept) = s_valid && s_ready.
- Pop: winc = (count != EMPTY) && !wfull && !wflush. Pop occurs whenever winc==1.
- Transitions, count_next = count + accept - pop:
  - EMPTY + accept -> ONE; word goes to head.
  - ONE + accept + pop -> ONE; new word goes to head.
  - ONE + accept, no pop -> TWO; word goes to tail.
  - ONE + pop, no accept -> EMPTY.
  - TWO + pop -> ONE; tail moves to head.
  - TWO never accepts.
- Ordering: strict FIFO. No word is dropped or duplicated except by wflush.
- wflush: next count=EMPTY. winc=0 and s_ready=0 in the flush cycle. Words offered in that cycle are not accepted. wflush has priority over push and pop.
- wfull high: winc held 0 and head held stable. Up to 2 further upstream words are absorbed, then s_ready drops.
- Occupancy:
  - wlevel_next = gray2bin(wptr) - gray2bin(wq2_rptr), modulo 2**(ADDRSIZE+1).
  - Registered, 1-cycle latency. Range 0..2**ADDRSIZE; pointer wrap is handled by the modular subtract.
  - walmost_full_next = (wlevel_next >= AF_THRESH), registered alongside wlevel.
- Pessimism: wlevel may overstate occupancy because the synchronized read pointer lags. This is acceptable. It never understates.
- Reset mid-operation: buffered words are discarded. Outputs return to reset values in the next cycle.

Decomposition:
- Package fifo_pkg holds:
  - function gray2bin (parameterised width);
  - localparam PTR_W = ADDRSIZE+1;
  - state enum skid_state_t {EMPTY, ONE, TWO}.
- One sub-module, wr_skid_buf, implements the 2-entry skid buffer: push/pop/flush, head/tail, count.
- The top level adds winc gating and the occupancy/almost-full logic.

Test Plan:
- Reset: hold wrst_n=0 for 3 cycles with s_valid=1 -> s_ready=0, winc=0, wlevel=0 throughout. s_ready=1 in the first cycle after release.
- Streaming: s_valid=1, data 0x01..0x10 on consecutive cycles, wfull=0 -> winc high each cycle one cycle after accept. wdata sequence is 0x01..0x10 with no gaps.
- Backpressure: wfull=1 at count=ONE with s_valid=1 -> 0xA1 and 0xA2 accepted, s_ready=0 from the next cycle, winc=0. On wfull=0: wdata 0xA1 then 0xA2, then s_ready=1.
- Flush: count=TWO and wflush=1 with s_valid=1 -> no winc and no accept that cycle. Next cycle count=EMPTY and s_ready=1.
- Level/wrap: wptr=Gray(3), wq2_rptr=Gray(27) (binary 00011 vs 11011) -> wlevel=8 one cycle later, walmost_full=0. With wptr=Gray(7) -> wlevel=12, walmost_full=1.
- Full span: wptr=Gray(16), wq2_rptr=Gray(0) -> wlevel=16, walmost_full=1.
